// File: rtl/axi_pkg.sv
// Shared AXI encodings and the command-master state type.
package axi_pkg;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_ADDR,
    RD_DATA,
    RSP
  } m_state_t;

  // AxSIZE encoding for a beat of 'bytes' bytes (bytes must be a power of two).
  function automatic logic [2:0] axi_size_enc(input int unsigned bytes);
    logic [2:0] enc;
    enc = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if ((32'd1 << i) == bytes) enc = 3'(i);
    end
    return enc;
  endfunction

endpackage

// File: rtl/m_axi_cmd.sv
// Single-beat AXI3 master: turns a command stream into AW/W/B or AR/R
// transactions with exactly one transaction outstanding.
module m_axi_cmd
  import axi_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter logic [3:0]  AXI_ID     = 4'h0
) (
  input  logic                      clk,
  input  logic                      areset,
  // command stream
  input  logic                      cmd_valid_i,
  output logic                      cmd_ready_o,
  input  logic                      cmd_write_i,
  input  logic [ADDR_WIDTH-1:0]     cmd_addr_i,
  input  logic [DATA_WIDTH-1:0]     cmd_wdata_i,
  input  logic [DATA_WIDTH/8-1:0]   cmd_wstrb_i,
  // response stream
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic                      rsp_write_o,
  output logic [DATA_WIDTH-1:0]     rsp_rdata_o,
  output logic [1:0]                rsp_resp_o,
  output logic [15:0]               wr_count_o,
  output logic [15:0]               rd_count_o,
  // write address channel
  output logic [3:0]                awid_o,
  output logic [ADDR_WIDTH-1:0]     awaddr_o,
  output logic [3:0]                awlen_o,
  output logic [2:0]                awsize_o,
  output logic [1:0]                awburst_o,
  output logic                      awvalid_o,
  input  logic                      awready_i,
  // write data channel
  output logic [3:0]                wid_o,
  output logic [DATA_WIDTH-1:0]     wdata_o,
  output logic [DATA_WIDTH/8-1:0]   wstrb_o,
  output logic                      wlast_o,
  output logic                      wvalid_o,
  input  logic                      wready_i,
  // write response channel
  input  logic [3:0]                bid_i,
  input  logic [1:0]                bresp_i,
  input  logic                      bvalid_i,
  output logic                      bready_o,
  // read address channel
  output logic [3:0]                arid_o,
  output logic [ADDR_WIDTH-1:0]     araddr_o,
  output logic                      arvalid_o,
  input  logic                      arready_i,
  // read data channel
  input  logic [3:0]                rid_i,
  input  logic [DATA_WIDTH-1:0]     rdata_i,
  input  logic                      rlast_i,
  input  logic                      rvalid_i,
  output logic                      rready_o
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  m_state_t state_q, state_d;

  logic                    write_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [STRB_WIDTH-1:0]   wstrb_q;
  logic                    aw_done_q;
  logic                    w_done_q;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q;
  logic [1:0]              rsp_resp_q;
  logic [15:0]             wr_cnt_q;
  logic [15:0]             rd_cnt_q;

  logic cmd_hs, aw_hs, w_hs, b_hs, ar_hs, r_hs, rsp_hs;

  // Handshakes are derived from state and done flags directly rather than
  // from the valid outputs, so the next-state logic has no combinational
  // dependence on its own outputs.
  assign cmd_hs = cmd_valid_i && (state_q == IDLE) && areset;
  assign aw_hs  = (state_q == WR_REQ)  && !aw_done_q && awready_i;
  assign w_hs   = (state_q == WR_REQ)  && !w_done_q  && wready_i;
  assign b_hs   = (state_q == WR_RESP) && bvalid_i;
  assign ar_hs  = (state_q == RD_ADDR) && arready_i;
  assign r_hs   = (state_q == RD_DATA) && rvalid_i;
  assign rsp_hs = (state_q == RSP)     && rsp_ready_i;

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    cmd_ready_o = 1'b0;
    awvalid_o   = 1'b0;
    wvalid_o    = 1'b0;
    wlast_o     = 1'b0;
    bready_o    = 1'b0;
    arvalid_o   = 1'b0;
    rready_o    = 1'b0;
    rsp_valid_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        cmd_ready_o = areset;
        if (cmd_hs) state_d = cmd_write_i ? WR_REQ : RD_ADDR;
      end
      WR_REQ: begin
        awvalid_o = !aw_done_q;
        wvalid_o  = !w_done_q;
        wlast_o   = !w_done_q;
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = WR_RESP;
      end
      WR_RESP: begin
        bready_o = 1'b1;
        if (b_hs) state_d = RSP;
      end
      RD_ADDR: begin
        arvalid_o = 1'b1;
        if (ar_hs) state_d = RD_DATA;
      end
      RD_DATA: begin
        rready_o = 1'b1;
        if (r_hs) state_d = RSP;
      end
      RSP: begin
        rsp_valid_o = 1'b1;
        if (rsp_hs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= AXI_RESP_OKAY;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
    end else begin
      if (cmd_hs) begin
        write_q   <= cmd_write_i;
        addr_q    <= cmd_addr_i;
        wdata_q   <= cmd_wdata_i;
        wstrb_q   <= cmd_wstrb_i;
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
      end
      if (aw_hs) aw_done_q <= 1'b1;
      if (w_hs)  w_done_q  <= 1'b1;
      if (b_hs) begin
        rsp_rdata_q <= '0;
        rsp_resp_q  <= (bid_i != AXI_ID) ? AXI_RESP_SLVERR : bresp_i;
      end
      if (r_hs) begin
        rsp_rdata_q <= rdata_i;
        rsp_resp_q  <= ((rid_i != AXI_ID) || !rlast_i) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
      end
      if (rsp_hs) begin
        if (write_q) wr_cnt_q <= wr_cnt_q + 16'd1;
        else         rd_cnt_q <= rd_cnt_q + 16'd1;
      end
    end
  end

  assign awid_o      = AXI_ID;
  assign wid_o       = AXI_ID;
  assign arid_o      = AXI_ID;
  assign awlen_o     = 4'h0;
  assign awsize_o    = axi_size_enc(STRB_WIDTH);
  assign awburst_o   = AXI_BURST_INCR;
  assign awaddr_o    = addr_q;
  assign araddr_o    = addr_q;
  assign wdata_o     = wdata_q;
  assign wstrb_o     = wstrb_q;
  assign rsp_write_o = write_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_resp_o  = rsp_resp_q;
  assign wr_count_o  = wr_cnt_q;
  assign rd_count_o  = rd_cnt_q;

endmodule
